vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/SVGA raster timing generator. Produces sync, blanking, pixel
//  position and frame-event strobes for any mode set by parameters.
//  Sits between the pixel-clock strobe divider and the pixel/framebuffer pipeline.
//  All outputs are registered and glitch-free.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch (pixels)
//  H_SYNC   96   horizontal sync width (pixels)
//  H_BP     48   horizontal back porch (pixels)
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vertical sync width (lines)
//  V_BP     33   vertical back porch (lines)
//  HS_POL   0    hsync asserted level (0 = active low)
//  VS_POL   0    vsync asserted level (0 = active low)
//  CW       11   counter/position width; must hold max(H_TOTAL,V_TOTAL)-1
//  FW       16   frame counter width
// PORTS
//  i_clk        in   1   base clock
//  i_rst        in   1   synchronous, active-high reset; restarts the frame
//  i_pix_stb    in   1   pixel strobe; one pixel advance per cycle it is high
//  o_hs         out  1   horizontal sync, level per HS_POL
//  o_vs         out  1   vertical sync, level per VS_POL
//  o_active     out  1   high while (h,v) is inside the visible area
//  o_blanking   out  1   ~o_active
//  o_x          out  CW  min(h, H_ACTIVE-1)
//  o_y          out  CW  min(v, V_ACTIVE-1)
//  o_h_count    out  CW  raw horizontal counter h
//  o_v_count    out  CW  raw vertical counter v
//  o_line_start out  1   1-clk pulse: h became 0
//  o_animate    out  1   1-clk pulse: (h,v) became (0,V_ACTIVE), end of visible area
//  o_screenend  out  1   1-clk pulse: (h,v) became (0,0), frame wrap
//  o_frame      out  FW  completed-frame count, wraps modulo 2^FW
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Axis order on both
//    axes: active, front porch, sync, back porch. h in [0,H_TOTAL-1], v in [0,V_TOTAL-1].
//  - Reset (priority over i_pix_stb): h=v=0, o_frame=0, o_x=o_y=0, o_active=1,
//    o_blanking=0, o_hs=~HS_POL, o_vs=~VS_POL, all strobes 0. The first i_pix_stb
//    after reset moves to (1,0).
//  - On an i_pix_stb cycle: h==H_TOTAL-1 -> h=0, v advances; else h+1.
//    v==V_TOTAL-1 at line end -> v=0, o_frame+1 (same edge).
//  - Outputs are computed from the next (h,v) and registered on the advancing edge,
//    so every output describes the counter value it is presented with (0 latency
//    relative to o_h_count/o_v_count). Without i_pix_stb all level outputs hold.
//  - hsync asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the
//    analogous v window; both are evaluated per pixel (vsync may change mid-line at h=0 only).
//  - Strobes are high for exactly one i_clk cycle after the advancing edge,
//    independent of the pixel strobe divide ratio; they are never asserted on the reset edge.
//  - o_screenend and o_line_start coincide at frame wrap; o_animate and o_line_start
//    coincide at v=V_ACTIVE.
//  - Reset mid-line/mid-frame: immediate return to (0,0) without an o_screenend
//    pulse; o_frame cleared.
//  - i_pix_stb held high continuously is legal (one pixel per clock).
// STRUCTURE
//  - Package vga_timing_pkg: mode-preset constants (640x480@60, 800x600@60,
//    1280x720@60) as H_*/V_*/POL localparams, plus clog2-based width helper.
//  - Sub-module vga_axis_counter (params ACTIVE,FP,SYNC,BP,POL,CW): counter with
//    enable, wrap flag, sync and active decode; instantiated for H (enable =
//    i_pix_stb) and V (enable = i_pix_stb & H wrap). Top level registers outputs/strobes.
// TESTING
//  - Reset then 800*525 strobes (defaults): o_screenend exactly once, at the 420000th
//    strobe; o_frame 0->1; o_hs low for exactly 96 strobes per line, starting at h=656.
//  - Per line: o_active high for h=0..639, o_x saturates at 639 for h>=640; o_vs low
//    exactly for v=490..491; o_animate pulses once when (0,480) is reached.
//  - i_pix_stb every 4th clock: all strobes are exactly 1 clk wide; levels change only on
//    strobe edges.
//  - i_rst asserted at (400,300) together with i_pix_stb: next state (0,0), o_frame=0,
//    no o_screenend pulse; the following strobe gives (1,0).
//  - Override to 800x600 (40/128/88, 1/4/23, HS_POL=VS_POL=1, total 1056x628): hsync high
//    for h=840..967; o_frame wraps 2^FW-1 -> 0 with small FW=2.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode presets and a counter-width helper for the VGA timing generator
package vga_timing_pkg;
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;
    localparam bit          VGA640_HS_POL   = 1'b0;
    localparam bit          VGA640_VS_POL   = 1'b0;

    localparam int unsigned SVGA800_H_ACTIVE = 800;
    localparam int unsigned SVGA800_H_FP     = 40;
    localparam int unsigned SVGA800_H_SYNC   = 128;
    localparam int unsigned SVGA800_H_BP     = 88;
    localparam int unsigned SVGA800_V_ACTIVE = 600;
    localparam int unsigned SVGA800_V_FP     = 1;
    localparam int unsigned SVGA800_V_SYNC   = 4;
    localparam int unsigned SVGA800_V_BP     = 23;
    localparam bit          SVGA800_HS_POL   = 1'b1;
    localparam bit          SVGA800_VS_POL   = 1'b1;

    localparam int unsigned HD720_H_ACTIVE = 1280;
    localparam int unsigned HD720_H_FP     = 110;
    localparam int unsigned HD720_H_SYNC   = 40;
    localparam int unsigned HD720_H_BP     = 220;
    localparam int unsigned HD720_V_ACTIVE = 720;
    localparam int unsigned HD720_V_FP     = 5;
    localparam int unsigned HD720_V_SYNC   = 5;
    localparam int unsigned HD720_V_BP     = 20;
    localparam bit          HD720_HS_POL   = 1'b1;
    localparam bit          HD720_VS_POL   = 1'b1;

    // bits needed to hold 0..total-1
    function automatic int unsigned cnt_width(input int unsigned total);
        return $clog2(total);
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (active, front porch, sync, back porch) with wrap, sync and active decode
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : advance by one position
//   count_o      : current position; next_o: position after this edge
//   wrap_o       : current position is the last one of the axis
//   sync_o       : sync level (per POL) for next_o; active_o: next_o lies in the visible span
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter bit          POL    = 1'b0,
    parameter int unsigned CW     = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] next_o,
    output logic          wrap_o,
    output logic          sync_o,
    output logic          active_o
);
    localparam int unsigned   TOTAL  = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_S = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_E = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] ACT_E  = CW'(ACTIVE);

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap_o  = cnt_q == LAST;
    assign count_o = cnt_q;
    assign next_o  = cnt_d;

    always_comb begin
        cnt_d = en_i ? (wrap_o ? '0 : cnt_q + CW'(1)) : cnt_q;
    end

    // decoded from the next position so the registered outputs line up with the count
    assign active_o = cnt_d < ACT_E;
    assign sync_o   = ((cnt_d >= SYNC_S) && (cnt_d < SYNC_E)) ~^ POL;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with registered sync, blanking, position and frame strobes
//   i_clk, i_rst       : base clock, synchronous active-high reset (restarts the frame)
//   i_pix_stb          : one pixel advance per cycle it is high
//   o_hs, o_vs         : sync levels per HS_POL/VS_POL
//   o_active/o_blanking: inside / outside the visible area
//   o_x, o_y           : position clamped to the visible area; o_h_count/o_v_count raw counters
//   o_line_start, o_animate, o_screenend : one-clock event strobes; o_frame completed frames
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FP     = VGA640_H_FP,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BP     = VGA640_H_BP,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FP     = VGA640_V_FP,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BP     = VGA640_V_BP,
    parameter bit          HS_POL   = VGA640_HS_POL,
    parameter bit          VS_POL   = VGA640_VS_POL,
    parameter int unsigned CW       = 11,
    parameter int unsigned FW       = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_active,
    output logic          o_blanking,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic [CW-1:0] o_h_count,
    output logic [CW-1:0] o_v_count,
    output logic          o_line_start,
    output logic          o_animate,
    output logic          o_screenend,
    output logic [FW-1:0] o_frame
);
    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);

    logic [CW-1:0] h_d, v_d;
    logic          h_wrap, v_wrap, h_sync_d, v_sync_d, h_act_d, v_act_d;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
    ) u_h (
        .clk_i(i_clk), .rst_i(i_rst), .en_i(i_pix_stb),
        .count_o(o_h_count), .next_o(h_d), .wrap_o(h_wrap),
        .sync_o(h_sync_d), .active_o(h_act_d)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
    ) u_v (
        .clk_i(i_clk), .rst_i(i_rst), .en_i(i_pix_stb & h_wrap),
        .count_o(o_v_count), .next_o(v_d), .wrap_o(v_wrap),
        .sync_o(v_sync_d), .active_o(v_act_d)
    );

    logic          hs_q, vs_q, active_q, line_start_q, animate_q, screenend_q;
    logic          line_start_d, animate_d, screenend_d;
    logic [CW-1:0] x_q, y_q, x_d, y_d;
    logic [FW-1:0] frame_q, frame_d;

    // strobes are gated by i_pix_stb so they last one clock regardless of the divide ratio
    always_comb begin
        x_d          = h_act_d ? h_d : X_MAX;
        y_d          = v_act_d ? v_d : Y_MAX;
        line_start_d = i_pix_stb & (h_d == '0);
        animate_d    = line_start_d & (v_d == V_ACT);
        screenend_d  = line_start_d & (v_d == '0);
        frame_d      = frame_q + FW'(i_pix_stb & h_wrap & v_wrap);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_q         <= ~HS_POL;
            vs_q         <= ~VS_POL;
            active_q     <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            line_start_q <= 1'b0;
            animate_q    <= 1'b0;
            screenend_q  <= 1'b0;
            frame_q      <= '0;
        end else begin
            hs_q         <= h_sync_d;
            vs_q         <= v_sync_d;
            active_q     <= h_act_d & v_act_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_start_q <= line_start_d;
            animate_q    <= animate_d;
            screenend_q  <= screenend_d;
            frame_q      <= frame_d;
        end
    end

    assign o_hs         = hs_q;
    assign o_vs         = vs_q;
    assign o_active     = active_q;
    assign o_blanking   = ~active_q;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_line_start = line_start_q;
    assign o_animate    = animate_q;
    assign o_screenend  = screenend_q;
    assign o_frame      = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator in 640x480, 800x600 and a tiny mode
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 640x480 defaults
    logic        a_rst, a_stb, a_hs, a_vs, a_act, a_blank, a_ls, a_an, a_se;
    logic [10:0] a_x, a_y, a_h, a_v;
    logic [15:0] a_fr;
    vga_timing_gen u_a (
        .i_clk(clk), .i_rst(a_rst), .i_pix_stb(a_stb), .o_hs(a_hs), .o_vs(a_vs),
        .o_active(a_act), .o_blanking(a_blank), .o_x(a_x), .o_y(a_y),
        .o_h_count(a_h), .o_v_count(a_v), .o_line_start(a_ls), .o_animate(a_an),
        .o_screenend(a_se), .o_frame(a_fr)
    );

    // 800x600, positive syncs, 2-bit frame counter
    logic        b_rst, b_stb, b_hs, b_vs, b_act, b_blank, b_ls, b_an, b_se;
    logic [10:0] b_x, b_y, b_h, b_v;
    logic [1:0]  b_fr;
    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11), .FW(2)
    ) u_b (
        .i_clk(clk), .i_rst(b_rst), .i_pix_stb(b_stb), .o_hs(b_hs), .o_vs(b_vs),
        .o_active(b_act), .o_blanking(b_blank), .o_x(b_x), .o_y(b_y),
        .o_h_count(b_h), .o_v_count(b_v), .o_line_start(b_ls), .o_animate(b_an),
        .o_screenend(b_se), .o_frame(b_fr)
    );

    // tiny 8x6 raster: H 4/1/2/1, V 3/1/1/1, 48 strobes per frame
    logic       c_rst, c_stb, c_hs, c_vs, c_act, c_blank, c_ls, c_an, c_se;
    logic [3:0] c_x, c_y, c_h, c_v;
    logic [1:0] c_fr;
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(2)
    ) u_c (
        .i_clk(clk), .i_rst(c_rst), .i_pix_stb(c_stb), .o_hs(c_hs), .o_vs(c_vs),
        .o_active(c_act), .o_blanking(c_blank), .o_x(c_x), .o_y(c_y),
        .o_h_count(c_h), .o_v_count(c_v), .o_line_start(c_ls), .o_animate(c_an),
        .o_screenend(c_se), .o_frame(c_fr)
    );

    task automatic a_pix();
        a_stb = 1'b1;
        @(negedge clk);
        a_stb = 1'b0;
    endtask

    task automatic b_pix();
        b_stb = 1'b1;
        @(negedge clk);
        b_stb = 1'b0;
    endtask

    task automatic c_pix();
        c_stb = 1'b1;
        @(negedge clk);
        c_stb = 1'b0;
    endtask

    typedef struct {
        int adv;
        int h; int v; int x; int y;
        int act; int hs; int vs; int ls; int an; int se;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int hs_cnt, act_cnt, ls_cnt, first_hs, last_hs, blk_err, wide, lvl, snap_h, snap_hs, snap_act;
        int mh, mv;
        tbl[0]  = '{0,   0,   0, 0,   0, 1, 1, 1, 0, 0, 0};
        tbl[1]  = '{1,   1,   0, 1,   0, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{638, 639, 0, 639, 0, 1, 1, 1, 0, 0, 0};
        tbl[3]  = '{1,   640, 0, 639, 0, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{15,  655, 0, 639, 0, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{1,   656, 0, 639, 0, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{95,  751, 0, 639, 0, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{1,   752, 0, 639, 0, 0, 1, 1, 0, 0, 0};
        tbl[8]  = '{47,  799, 0, 639, 0, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1,   0,   1, 0,   1, 1, 1, 1, 1, 0, 0};
        tbl[10] = '{1,   1,   1, 1,   1, 1, 1, 1, 0, 0, 0};

        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_stb = 1'b0; b_stb = 1'b0; c_stb = 1'b0;
        repeat (3) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        check("a_reset_blank", a_blank, 0);
        check("a_reset_frame", a_fr, 0);

        for (int i = 0; i < 11; i++) begin
            repeat (tbl[i].adv) a_pix();
            check($sformatf("a_h[%0d]", i), a_h, tbl[i].h);
            check($sformatf("a_v[%0d]", i), a_v, tbl[i].v);
            check($sformatf("a_x[%0d]", i), a_x, tbl[i].x);
            check($sformatf("a_y[%0d]", i), a_y, tbl[i].y);
            check($sformatf("a_act[%0d]", i), a_act, tbl[i].act);
            check($sformatf("a_hs[%0d]", i), a_hs, tbl[i].hs);
            check($sformatf("a_vs[%0d]", i), a_vs, tbl[i].vs);
            check($sformatf("a_ls[%0d]", i), a_ls, tbl[i].ls);
            check($sformatf("a_an[%0d]", i), a_an, tbl[i].an);
            check($sformatf("a_se[%0d]", i), a_se, tbl[i].se);
        end

        // one full line at one pixel per clock, from (1,1) to (1,2)
        hs_cnt = 0; act_cnt = 0; ls_cnt = 0; first_hs = -1; blk_err = 0;
        for (int k = 0; k < 800; k++) begin
            a_pix();
            if (!a_hs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = a_h;
            end
            act_cnt += a_act;
            ls_cnt += a_ls;
            if (a_blank == a_act) blk_err++;
        end
        check("a_line_hs_low", hs_cnt, 96);
        check("a_line_hs_first", first_hs, 656);
        check("a_line_active", act_cnt, 640);
        check("a_line_ls", ls_cnt, 1);
        check("a_line_blank", blk_err, 0);
        check("a_line_end_h", a_h, 1);
        check("a_line_end_v", a_v, 2);

        // pixel strobe every 4th clock, 799 strobes from (1,2) to (0,3)
        ls_cnt = 0; hs_cnt = 0; wide = 0; lvl = 0;
        for (int k = 0; k < 799; k++) begin
            a_pix();
            ls_cnt += a_ls;
            if (!a_hs) hs_cnt++;
            snap_h = a_h; snap_hs = a_hs; snap_act = a_act;
            repeat (3) begin
                @(negedge clk);
                if (a_ls || a_an || a_se) wide++;
                if (a_h != snap_h || a_hs != snap_hs || a_act != snap_act) lvl++;
            end
        end
        check("a_div4_ls", ls_cnt, 1);
        check("a_div4_hs_low", hs_cnt, 96);
        check("a_div4_wide", wide, 0);
        check("a_div4_hold", lvl, 0);
        check("a_div4_end_h", a_h, 0);
        check("a_div4_end_v", a_v, 3);

        // reset together with a strobe, mid-line
        repeat (400) a_pix();
        check("a_pre_rst_h", a_h, 400);
        a_rst = 1'b1; a_stb = 1'b1;
        @(negedge clk);
        a_rst = 1'b0; a_stb = 1'b0;
        check("a_rst_h", a_h, 0);
        check("a_rst_v", a_v, 0);
        check("a_rst_frame", a_fr, 0);
        check("a_rst_se", a_se, 0);
        check("a_rst_ls", a_ls, 0);
        check("a_rst_act", a_act, 1);
        check("a_rst_hs", a_hs, 1);
        a_pix();
        check("a_post_rst_h", a_h, 1);
        check("a_post_rst_v", a_v, 0);

        // 800x600 with positive syncs
        check("b_reset_hs", b_hs, 0);
        check("b_reset_vs", b_vs, 0);
        check("b_reset_act", b_act, 1);
        hs_cnt = 0; act_cnt = 0; first_hs = -1; last_hs = -1;
        for (int k = 0; k < 1056; k++) begin
            b_pix();
            if (b_hs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = b_h;
                last_hs = b_h;
            end
            act_cnt += b_act;
        end
        check("b_hs_high", hs_cnt, 128);
        check("b_hs_first", first_hs, 840);
        check("b_hs_last", last_hs, 967);
        check("b_active", act_cnt, 800);
        check("b_end_h", b_h, 0);
        check("b_end_v", b_v, 1);
        check("b_end_ls", b_ls, 1);
        check("b_end_vs", b_vs, 0);

        // tiny mode: full frames against an index-derived model, including frame wrap
        check("c_reset_se", c_se, 0);
        for (int k = 1; k <= 200; k++) begin
            c_pix();
            mh = k % 8;
            mv = (k / 8) % 6;
            check($sformatf("c_h@%0d", k), c_h, mh);
            check($sformatf("c_v@%0d", k), c_v, mv);
            check($sformatf("c_hs@%0d", k), c_hs, (mh == 5 || mh == 6) ? 0 : 1);
            check($sformatf("c_vs@%0d", k), c_vs, (mv == 4) ? 0 : 1);
            check($sformatf("c_act@%0d", k), c_act, (mh < 4 && mv < 3) ? 1 : 0);
            check($sformatf("c_y@%0d", k), c_y, (mv < 2) ? mv : 2);
            check($sformatf("c_ls@%0d", k), c_ls, (mh == 0) ? 1 : 0);
            check($sformatf("c_an@%0d", k), c_an, (mh == 0 && mv == 3) ? 1 : 0);
            check($sformatf("c_se@%0d", k), c_se, (k % 48 == 0) ? 1 : 0);
            check($sformatf("c_fr@%0d", k), c_fr, (k / 48) % 4);
        end

        // reset mid-frame inside vsync
        repeat (28) c_pix();
        check("c_pre_rst_h", c_h, 4);
        check("c_pre_rst_vs", c_vs, 0);
        c_rst = 1'b1; c_stb = 1'b1;
        @(negedge clk);
        c_rst = 1'b0; c_stb = 1'b0;
        check("c_rst_h", c_h, 0);
        check("c_rst_v", c_v, 0);
        check("c_rst_frame", c_fr, 0);
        check("c_rst_se", c_se, 0);
        check("c_rst_vs", c_vs, 1);
        c_pix();
        check("c_post_rst_h", c_h, 1);
        check("c_post_rst_v", c_v, 0);
        check("c_post_rst_se", c_se, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
